// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// cdb_arbiter_pkg : shared widths and source-id encoding for the CDB arbiter
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;

  localparam int ROB_SIZE_WIDTH = 4;
  localparam int CDB_VALUE_W    = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

endpackage

`default_nettype wire

// File: rtl/cdb_fifo.sv
// ============================================================================
// cdb_fifo : {tag, value} result queue with push, pop and synchronous flush
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_fifo #(
  parameter int TAG_W   = 4,
  parameter int VALUE_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [TAG_W-1:0]   push_tag,
  input  logic [VALUE_W-1:0] push_value,
  input  logic               pop,
  output logic [TAG_W-1:0]   head_tag,
  output logic [VALUE_W-1:0] head_value,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0]   tag_mem   [DEPTH];
  logic [VALUE_W-1:0] value_mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[tail]   <= push_tag;
      value_mem[tail] <= push_value;
    end
  end

  assign head_tag   = tag_mem[head];
  assign head_value = value_mem[head];
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : round-robin arbitration of ALU and LSB results onto the CDB
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_W  = ROB_SIZE_WIDTH,
  parameter int QDEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   clear,
  input  logic                   alu_valid,
  input  logic [ROB_W-1:0]       alu_rob_id,
  input  logic [CDB_VALUE_W-1:0] alu_value,
  output logic                   alu_ready,
  input  logic                   lsb_valid,
  input  logic [ROB_W-1:0]       lsb_rob_id,
  input  logic [CDB_VALUE_W-1:0] lsb_value,
  output logic                   lsb_ready,
  output logic                   cdb_valid,
  output logic [ROB_W-1:0]       cdb_rob_id,
  output logic [CDB_VALUE_W-1:0] cdb_value
);

  logic                   alu_full, alu_empty, lsb_full, lsb_empty;
  logic [ROB_W-1:0]       alu_head_tag, lsb_head_tag;
  logic [CDB_VALUE_W-1:0] alu_head_value, lsb_head_value;
  logic                   flush, alu_push, lsb_push, alu_pop, lsb_pop;
  logic                   grant;
  src_e                   grant_src;
  src_e                   last_grant;

  // Readiness comes from the registered count only, never a same-cycle pop
  assign alu_ready = !alu_full;
  assign lsb_ready = !lsb_full;
  assign flush     = rdy && clear;
  assign alu_push  = rdy && !clear && alu_valid && alu_ready;
  assign lsb_push  = rdy && !clear && lsb_valid && lsb_ready;
  assign alu_pop   = grant && (grant_src == SRC_ALU);
  assign lsb_pop   = grant && (grant_src == SRC_LSB);

  always_comb begin
    grant     = 1'b0;
    grant_src = SRC_ALU;
    if (rdy && !clear) begin
      if (!alu_empty && !lsb_empty) begin
        grant     = 1'b1;
        grant_src = (last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;
      end else if (!alu_empty) begin
        grant     = 1'b1;
        grant_src = SRC_ALU;
      end else if (!lsb_empty) begin
        grant     = 1'b1;
        grant_src = SRC_LSB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      last_grant <= SRC_ALU;
    end else if (rdy) begin
      if (clear) begin
        cdb_valid  <= 1'b0;
        last_grant <= SRC_ALU;
      end else if (grant) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= (grant_src == SRC_ALU) ? alu_head_tag : lsb_head_tag;
        cdb_value  <= (grant_src == SRC_ALU) ? alu_head_value : lsb_head_value;
        last_grant <= grant_src;
      end else begin
        cdb_valid  <= 1'b0;
      end
    end
  end

  cdb_fifo #(
    .TAG_W   (ROB_W),
    .VALUE_W (CDB_VALUE_W),
    .DEPTH   (QDEPTH)
  ) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (alu_push),
    .push_tag   (alu_rob_id),
    .push_value (alu_value),
    .pop        (alu_pop),
    .head_tag   (alu_head_tag),
    .head_value (alu_head_value),
    .full       (alu_full),
    .empty      (alu_empty)
  );

  cdb_fifo #(
    .TAG_W   (ROB_W),
    .VALUE_W (CDB_VALUE_W),
    .DEPTH   (QDEPTH)
  ) u_lsb_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (lsb_push),
    .push_tag   (lsb_rob_id),
    .push_value (lsb_value),
    .pop        (lsb_pop),
    .head_tag   (lsb_head_tag),
    .head_value (lsb_head_value),
    .full       (lsb_full),
    .empty      (lsb_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter : directed self-checking bench for cdb_arbiter (QDEPTH=2)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_rob_id, lsb_rob_id;
  logic [31:0] alu_value, lsb_value;
  logic        alu_ready, lsb_ready, cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;

  int compared   = 0;
  int mismatched = 0;

  // stream scenario tables
  logic [3:0]  a_ids [9];
  logic [3:0]  l_ids [9];
  int          a_n, l_n;
  int          e_id  [10];
  logic [31:0] e_val [10];
  bit          e_ar  [10];
  bit          e_lr  [10];

  cdb_arbiter #(.ROB_W(4), .QDEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .alu_valid  (alu_valid),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_ready  (alu_ready),
    .lsb_valid  (lsb_valid),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_ready  (lsb_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    alu_valid = 1'b0; lsb_valid = 1'b0; clear = 1'b0;
    alu_rob_id = '0;  lsb_rob_id = '0;
    alu_value = '0;   lsb_value = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic check_cdb(input string tag, input bit v, input int id, input logic [31:0] val);
    chk({tag, ".valid"}, {31'd0, cdb_valid}, {31'd0, v});
    if (v) begin
      chk({tag, ".id"}, {28'd0, cdb_rob_id}, 32'(id));
      chk({tag, ".value"}, cdb_value, val);
    end
  endtask

  task automatic check_ready(input string tag, input bit ar, input bit lr);
    chk({tag, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, ar});
    chk({tag, ".lsb_ready"}, {31'd0, lsb_ready}, {31'd0, lr});
  endtask

  task automatic push(input bit av, input int aid, input bit lv, input int lid);
    alu_valid = av; alu_rob_id = 4'(aid); alu_value = 32'hA000_0000 | 32'(aid);
    lsb_valid = lv; lsb_rob_id = 4'(lid); lsb_value = 32'hB000_0000 | 32'(lid);
  endtask

  // Each source holds its current id until it sees ready, then advances
  task automatic run_stream(input string name);
    int ai = 0;
    int li = 0;
    bit acc_a, acc_l;
    for (int c = 0; c < 10; c++) begin
      alu_valid  = (ai < a_n);
      alu_rob_id = a_ids[ai];
      alu_value  = 32'hA000_0000 | {28'd0, a_ids[ai]};
      lsb_valid  = (li < l_n);
      lsb_rob_id = l_ids[li];
      lsb_value  = 32'hB000_0000 | {28'd0, l_ids[li]};
      acc_a = alu_valid && alu_ready;
      acc_l = lsb_valid && lsb_ready;
      tick();
      if (acc_a) ai++;
      if (acc_l) li++;
      check_cdb($sformatf("%s[%0d]", name, c), e_id[c] >= 0, e_id[c], e_val[c]);
      check_ready($sformatf("%s[%0d]", name, c), e_ar[c], e_lr[c]);
    end
    quiet();
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1;
    quiet();

    // reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check_cdb($sformatf("idle[%0d]", i), 1'b0, 0, 32'h0);
      chk($sformatf("idle[%0d].id", i), {28'd0, cdb_rob_id}, 32'h0);
      chk($sformatf("idle[%0d].value", i), cdb_value, 32'h0);
      check_ready($sformatf("idle[%0d]", i), 1'b1, 1'b1);
      tick();
    end

    // single ALU push: broadcast for exactly one cycle, fields then hold
    alu_valid = 1'b1; alu_rob_id = 4'd3; alu_value = 32'hDEAD_BEEF;
    tick();
    quiet();
    check_cdb("single.N", 1'b0, 0, 32'h0);
    tick();
    check_cdb("single.N1", 1'b1, 3, 32'hDEAD_BEEF);
    tick();
    check_cdb("single.N2", 1'b0, 0, 32'h0);
    chk("single.N2.hold_id", {28'd0, cdb_rob_id}, 32'd3);
    chk("single.N2.hold_value", cdb_value, 32'hDEAD_BEEF);

    // both sources saturated: strict alternation, LSB wins the first tie
    do_reset();
    a_ids = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    l_ids = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    a_n = 4; l_n = 4;
    e_id  = '{-1, 9, 1, 10, 2, 11, 3, 12, 4, -1};
    e_val = '{32'h0, 32'hB000_0009, 32'hA000_0001, 32'hB000_000A, 32'hA000_0002,
              32'hB000_000B, 32'hA000_0003, 32'hB000_000C, 32'hA000_0004, 32'h0};
    e_ar  = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 1};
    e_lr  = '{1, 1, 0, 1, 0, 1, 1, 1, 1, 1};
    run_stream("sat");

    // LSB queue fills with 5,6; held id 7 enters only once a slot frees
    do_reset();
    a_ids = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    l_ids = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    a_n = 4; l_n = 4;
    e_id  = '{-1, 4, 1, 5, 2, 6, 3, 7, 4, -1};
    e_val = '{32'h0, 32'hB000_0004, 32'hA000_0001, 32'hB000_0005, 32'hA000_0002,
              32'hB000_0006, 32'hA000_0003, 32'hB000_0007, 32'hA000_0004, 32'h0};
    e_ar  = '{1, 0, 1, 0, 1, 0, 1, 1, 1, 1};
    e_lr  = '{1, 1, 0, 1, 0, 1, 1, 1, 1, 1};
    run_stream("full");

    // clear with entries queued and an ALU result offered
    do_reset();
    push(1'b1, 1, 1'b1, 2);
    tick();
    check_cdb("clr.e1", 1'b0, 0, 32'h0);
    push(1'b1, 3, 1'b1, 4);
    tick();
    check_cdb("clr.e2", 1'b1, 2, 32'hB000_0002);
    quiet();
    clear = 1'b1;
    push(1'b1, 7, 1'b0, 0);
    tick();
    quiet();
    check_cdb("clr.e3", 1'b0, 0, 32'h0);
    check_ready("clr.e3", 1'b1, 1'b1);
    tick();
    check_cdb("clr.e4", 1'b0, 0, 32'h0);
    push(1'b1, 8, 1'b1, 9);
    tick();
    quiet();
    check_cdb("clr.e5", 1'b0, 0, 32'h0);
    tick();
    check_cdb("clr.e6", 1'b1, 9, 32'hB000_0009);
    tick();
    check_cdb("clr.e7", 1'b1, 8, 32'hA000_0008);
    tick();
    check_cdb("clr.e8", 1'b0, 0, 32'h0);

    // rdy stall with a live broadcast and both queues loaded
    do_reset();
    push(1'b1, 1, 1'b1, 9);
    tick();
    push(1'b1, 2, 1'b1, 10);
    tick();
    check_cdb("stall.pre", 1'b1, 9, 32'hB000_0009);
    check_ready("stall.pre", 1'b0, 1'b1);
    rdy = 1'b0;
    push(1'b1, 5, 1'b1, 6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cdb($sformatf("stall[%0d]", i), 1'b1, 9, 32'hB000_0009);
      check_ready($sformatf("stall[%0d]", i), 1'b0, 1'b1);
    end
    quiet();
    rdy = 1'b1;
    tick();
    check_cdb("stall.r1", 1'b1, 1, 32'hA000_0001);
    tick();
    check_cdb("stall.r2", 1'b1, 10, 32'hB000_000A);
    tick();
    check_cdb("stall.r3", 1'b1, 2, 32'hA000_0002);

    // reset overrides a low rdy while a broadcast is live
    rdy = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cdb("rst_mid", 1'b0, 0, 32'h0);
    chk("rst_mid.id", {28'd0, cdb_rob_id}, 32'h0);
    chk("rst_mid.value", cdb_value, 32'h0);
    check_ready("rst_mid", 1'b1, 1'b1);
    rdy = 1'b1;
    tick();
    check_cdb("stall.r4", 1'b0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
